// File: rtl/led_pkg.sv
// Shared constants, state encoding and helpers for the LED bank arbiter.
package led_pkg;

  localparam int CLK_HZ  = 27000000;
  localparam int LED_W   = 6;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // One-hot encode an owner index; callers truncate to their requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin search: first set, non-excluded request at or after i_start, wrapping.
module led_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(i_start) + k) % NUM_REQ;
      if (!o_found && i_req[j] && !i_excl[j]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-slice arbiter sharing an active-low LED bank among NUM_REQ pattern sources.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SLICE_CYCLES = CLK_HZ,
  parameter int LED_W        = led_pkg::LED_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         led
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SLICE_CYCLES);

  state_e             r_state, w_next_state;
  logic [IDX_W-1:0]   r_owner, r_last, w_next_owner, w_start, w_pick_idx;
  logic [CNT_W-1:0]   r_cnt, w_next_cnt;
  logic [NUM_REQ-1:0] w_excl, w_grant_d;
  logic [LED_W-1:0]   w_led_d;
  logic               w_found;

  // In OWN the pointer equals the owner, so one search serves both release and expiry.
  assign w_start = (r_last == IDX_W'(NUM_REQ-1)) ? '0 : r_last + 1'b1;
  assign w_excl  = (r_state == OWN) ? NUM_REQ'(onehot(int'(r_owner))) : '0;

  led_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_start (w_start),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NUM_REQ-1);
      r_cnt   <= '0;
      grant   <= '0;
      led     <= '1;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_cnt   <= w_next_cnt;
      grant   <= w_grant_d;
      led     <= w_led_d;
      if (w_next_state == OWN) r_last <= w_next_owner;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_next_cnt   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next_state = OWN;
          w_next_owner = w_pick_idx;
        end
      end
      OWN: begin
        if (!req[r_owner]) begin
          if (w_found) w_next_owner = w_pick_idx;
          else         w_next_state = IDLE;
        end else if (r_cnt == CNT_W'(SLICE_CYCLES-1)) begin
          // Nobody else waiting means the owner is simply re-granted.
          if (w_found) w_next_owner = w_pick_idx;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_grant_d = '0;
    w_led_d   = '1;
    if (w_next_state == OWN) begin
      w_grant_d = NUM_REQ'(onehot(int'(w_next_owner)));
      w_led_d   = ~pattern[int'(w_next_owner)*LED_W +: LED_W];
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed self-checking bench for led_bank_arbiter with SLICE_CYCLES = 8 and four sources.
module tb_led_bank_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SLICE   = 8;
  localparam int LED_W   = 6;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] pattern;
  logic [NUM_REQ-1:0]       grant;
  logic [LED_W-1:0]         led;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt;

  led_bank_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .SLICE_CYCLES (SLICE),
    .LED_W        (LED_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_default_patterns();
    pattern = {6'd4, 6'd3, 6'd2, 6'd1};
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    set_default_patterns();

    // Reset with every source requesting.
    step(3);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_led", 32'(led), 32'h3F);
    rst = 1'b0;
    step(1);
    check("first_grant", 32'(grant), 32'b0001);
    check("first_led", 32'(led), 32'b111110);
    check("first_cnt", 32'(dut.r_cnt), 32'd0);

    // Two sources alternate slices with no gap.
    req = 4'b0101;
    step(7);
    check("alt_hold0_grant", 32'(grant), 32'b0001);
    check("alt_hold0_cnt", 32'(dut.r_cnt), 32'd7);
    step(1);
    check("alt_to2_grant", 32'(grant), 32'b0100);
    check("alt_to2_led", 32'(led), 32'b111100);
    check("alt_to2_cnt", 32'(dut.r_cnt), 32'd0);
    step(7);
    check("alt_hold2_grant", 32'(grant), 32'b0100);
    step(1);
    check("alt_to0_grant", 32'(grant), 32'b0001);
    check("alt_to0_led", 32'(led), 32'b111110);
    step(8);
    check("alt_to2b_grant", 32'(grant), 32'b0100);
    check("alt_to2b_led", 32'(led), 32'b111100);

    // Lone requester is re-granted at each slice boundary.
    req = 4'b0100;
    exp_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      exp_cnt = (exp_cnt + 1) % SLICE;
      check($sformatf("solo_grant_%0d", c), 32'(grant), 32'b0100);
      check($sformatf("solo_cnt_%0d", c), 32'(dut.r_cnt), 32'(exp_cnt));
    end

    // Owner release hands off directly to the next requester.
    req = 4'b0001;
    step(1);
    check("rel_to0_grant", 32'(grant), 32'b0001);
    check("rel_to0_led", 32'(led), 32'b111110);
    check("rel_to0_cnt", 32'(dut.r_cnt), 32'd0);
    req = 4'b1001;
    step(3);
    check("mid_cnt", 32'(dut.r_cnt), 32'd3);
    check("mid_grant", 32'(grant), 32'b0001);
    req = 4'b1000;
    step(1);
    check("rel_to3_grant", 32'(grant), 32'b1000);
    check("rel_to3_led", 32'(led), 32'b111011);
    check("rel_to3_cnt", 32'(dut.r_cnt), 32'd0);

    // Owner pattern follows one cycle later; non-owner patterns ignored.
    pattern[3*LED_W +: LED_W] = 6'b101010;
    step(1);
    check("own_pat_led", 32'(led), 32'b010101);
    pattern[0 +: LED_W] = 6'b111111;
    step(1);
    check("other_pat_led", 32'(led), 32'b010101);
    set_default_patterns();

    // All requests drop, then a fresh request from idle.
    req = 4'b0000;
    step(1);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_led", 32'(led), 32'h3F);
    step(2);
    check("idle_hold_grant", 32'(grant), 32'h0);
    req = 4'b0010;
    step(1);
    check("wake1_grant", 32'(grant), 32'b0010);
    check("wake1_led", 32'(led), 32'b111101);

    // Asynchronous reset mid-slice, then pointer restarts at source 0.
    step(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_led", 32'(led), 32'h3F);
    req = 4'b1111;
    step(2);
    check("rst_hold_grant", 32'(grant), 32'h0);
    rst = 1'b0;
    step(1);
    check("post_rst_grant", 32'(grant), 32'b0001);
    check("post_rst_led", 32'(led), 32'b111110);
    check("post_rst_cnt", 32'(dut.r_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
